// File: rtl/i2s_tx_mc.sv
// Multi-channel I2S / left-justified / TDM serial audio transmitter with a frame FIFO.
// Frames are requested one at a time, buffered, and shifted out MSB-first on sdo.
package audioport_pkg;
    // System clocks per serial-clock period for each sample rate
    localparam logic [7:0] MCLK_DIV_48000  = 8'd8;
    localparam logic [7:0] MCLK_DIV_96000  = 8'd4;
    localparam logic [7:0] MCLK_DIV_192000 = 8'd2;
endpackage

module i2s_tx_mc #(
    parameter int DATA_W     = 24,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         play_in,
    input  logic                         tick_in,
    input  logic [CHANNELS*DATA_W-1:0]   audio_in,
    input  logic                         cfg_in,
    input  logic [31:0]                  cfg_reg_in,
    output logic                         req_out,
    output logic                         ws_out,
    output logic                         sck_out,
    output logic                         sdo_out,
    output logic                         underrun_out
);
    import audioport_pkg::*;

    localparam int FRAME_W = CHANNELS * DATA_W;
    localparam int HALF_W  = FRAME_W / 2;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int PW      = AW + 1;
    localparam int BW      = $clog2(FRAME_W);
    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);
    localparam logic [BW-1:0] HALF_BIT = BW'(HALF_W);
    localparam logic [BW-1:0] HALF_PRE = BW'(HALF_W - 1);

    typedef enum logic [2:0] {STOP, FILL, REQ, LOAD, PLAY} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FRAME_W-1:0]   mem_q [FIFO_DEPTH];
    logic [7:0]           div_q, div_d;
    logic                 mode_q, mode_d;
    logic [7:0]           sck_ctr_q, sck_ctr_d;
    logic [BW-1:0]        bit_ctr_q, bit_ctr_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic                 ws_q, ws_d;
    logic                 sck_q, sck_d;
    logic                 und_q, und_d;

    logic       full, empty, wr_en, cfg_ok, bnd, load_bnd;
    logic [7:0] half_div;
    logic       unused_cfg;

    assign unused_cfg = ^cfg_reg_in[31:3];

    // Wrap bit distinguishes full from empty when the index bits match
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign wr_en    = tick_in && (state_q != STOP) && !full;
    assign cfg_ok   = cfg_in && (state_q == STOP) && !play_in;
    assign half_div = {1'b0, div_q[7:1]};
    assign bnd      = (state_q == PLAY) && (sck_ctr_q == half_div);
    assign load_bnd = bnd && (bit_ctr_q == '0);

    assign req_out      = (state_q == REQ) || (load_bnd && play_in);
    assign ws_out       = ws_q;
    assign sck_out      = sck_q;
    assign sdo_out      = shreg_q[FRAME_W-1];
    assign underrun_out = und_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            STOP: if (play_in) state_d = FILL;
            FILL: begin
                if (!play_in)   state_d = STOP;
                else if (!full) state_d = REQ;
                else            state_d = PLAY;
            end
            REQ:  state_d = play_in ? LOAD : STOP;
            LOAD: begin
                if (!play_in)     state_d = STOP;
                else if (tick_in) state_d = FILL;
            end
            PLAY: if (load_bnd && !play_in) state_d = STOP;
            default: state_d = STOP;
        endcase
    end

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        div_d     = div_q;
        mode_d    = mode_q;
        sck_ctr_d = '0;
        bit_ctr_d = bit_ctr_q;
        shreg_d   = shreg_q;
        ws_d      = ws_q;
        und_d     = und_q;

        if (cfg_ok) begin
            mode_d = cfg_reg_in[2];
            case (cfg_reg_in[1:0])
                2'b00:   div_d = MCLK_DIV_48000;
                2'b01:   div_d = MCLK_DIV_96000;
                2'b10:   div_d = MCLK_DIV_192000;
                default: div_d = div_q;
            endcase
        end

        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);

        if (state_q == PLAY)
            sck_ctr_d = (sck_ctr_q == div_q - 8'd1) ? '0 : sck_ctr_q + 8'd1;

        if (bnd) begin
            bit_ctr_d = (bit_ctr_q == LAST_BIT) ? '0 : bit_ctr_q + BW'(1);
            if (bit_ctr_q == '0) begin
                if (play_in) begin
                    if (empty) begin
                        shreg_d = '0;
                        und_d   = 1'b1;
                    end else begin
                        shreg_d  = mem_q[rd_ptr_q[AW-1:0]];
                        rd_ptr_d = rd_ptr_q + PW'(1);
                    end
                end
            end else begin
                shreg_d = shreg_q << 1;
            end
            // I2S leads each half-frame MSB by one bit; left-justified aligns with it
            if (mode_q) begin
                if (bit_ctr_q == '0)           ws_d = 1'b0;
                else if (bit_ctr_q == HALF_BIT) ws_d = 1'b1;
            end else begin
                if (bit_ctr_q == HALF_PRE)      ws_d = 1'b1;
                else if (bit_ctr_q == LAST_BIT) ws_d = 1'b0;
            end
        end

        // Clearing on entry to STOP keeps the outputs low from the first STOP cycle
        if (state_d == STOP) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            und_d     = 1'b0;
            sck_ctr_d = '0;
            bit_ctr_d = '0;
            shreg_d   = '0;
            ws_d      = 1'b0;
        end

        sck_d = (state_d == PLAY) && (sck_ctr_d < half_div);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= STOP;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            div_q     <= MCLK_DIV_48000;
            mode_q    <= 1'b0;
            sck_ctr_q <= '0;
            bit_ctr_q <= '0;
            shreg_q   <= '0;
            ws_q      <= 1'b0;
            sck_q     <= 1'b0;
            und_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            div_q     <= div_d;
            mode_q    <= mode_d;
            sck_ctr_q <= sck_ctr_d;
            bit_ctr_q <= bit_ctr_d;
            shreg_q   <= shreg_d;
            ws_q      <= ws_d;
            sck_q     <= sck_d;
            und_q     <= und_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= audio_in;
    end

endmodule

// File: tb/tb_i2s_tx_mc.sv
// Scoreboard bench for i2s_tx_mc: a stereo 24-bit instance and a 4-channel 16-bit TDM instance.
// Expected {ws,sdo} pairs are queued per loaded frame and checked at every sck rising edge.
module tb_i2s_tx_mc;
    localparam int TMO = 20000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  play = '0;
    logic [1:0]  tick = '0;
    logic [1:0]  cfg = '0;
    logic [31:0] cfg_reg0 = '0;
    logic [31:0] cfg_reg1 = '0;
    logic [47:0] audio0 = '0;
    logic [63:0] audio1 = '0;
    logic        req0, req1, ws0, ws1, sck0, sck1, sdo0, sdo1, und0, und1;
    logic [1:0]  req_w, ws_w, sck_w, sdo_w, und_w;

    assign req_w = {req1, req0};
    assign ws_w  = {ws1, ws0};
    assign sck_w = {sck1, sck0};
    assign sdo_w = {sdo1, sdo0};
    assign und_w = {und1, und0};

    i2s_tx_mc #(.DATA_W(24), .CHANNELS(2), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .play_in(play[0]), .tick_in(tick[0]), .audio_in(audio0),
        .cfg_in(cfg[0]), .cfg_reg_in(cfg_reg0), .req_out(req0), .ws_out(ws0),
        .sck_out(sck0), .sdo_out(sdo0), .underrun_out(und0));

    i2s_tx_mc #(.DATA_W(16), .CHANNELS(4), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .play_in(play[1]), .tick_in(tick[1]), .audio_in(audio1),
        .cfg_in(cfg[1]), .cfg_reg_in(cfg_reg1), .req_out(req1), .ws_out(ws1),
        .sck_out(sck1), .sdo_out(sdo1), .underrun_out(und1));

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [1:0]  eq0[$], eq1[$];
    logic [63:0] mf0[$], mf1[$];
    logic [63:0] flist [2][8];
    int nfeed[2], fidx[2], loads[2], extra_at[2], sess[2], rise_sess[2], last_rise[2], exp_div[2];
    bit exp_mode[2], und_exp[2], playing[2], pend[2], extra_pend[2], have_rise[2], prev_sck[2];
    bit mon_off = 1'b0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event", nm);
    endtask

    function automatic int fw(input int u);
        return (u == 0) ? 48 : 64;
    endfunction

    function automatic int qsz(input int u);
        return (u == 0) ? eq0.size() : eq1.size();
    endfunction

    task automatic push_item(input int u, input logic [1:0] it);
        if (u == 0) eq0.push_back(it);
        else        eq1.push_back(it);
    endtask

    // Expected {ws,sdo} for every bit of one frame, MSB first
    task automatic push_frame(input int u, input logic [63:0] fr);
        int f, h;
        logic w;
        f = fw(u);
        h = f / 2;
        for (int k = 0; k < f; k++) begin
            if (exp_mode[u]) w = (k >= h);
            else             w = (k >= h - 1) && (k <= f - 2);
            push_item(u, {w, fr[f-1-k]});
        end
    endtask

    task automatic model_push(input int u, input logic [63:0] fr);
        if (u == 0) begin if (mf0.size() < 4) mf0.push_back(fr); end
        else        begin if (mf1.size() < 4) mf1.push_back(fr); end
    endtask

    task automatic set_audio(input int u, input logic [63:0] fr);
        if (u == 0) audio0 = fr[47:0];
        else        audio1 = fr;
    endtask

    // Feeder: answers each req_out with one tick_in a cycle later; models FIFO occupancy
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (mon_off) begin
                tick[u] = 1'b0;
                pend[u] = 1'b0;
                extra_pend[u] = 1'b0;
            end else begin
                if (tick[u]) begin
                    tick[u] = 1'b0;
                    if (extra_pend[u]) begin
                        extra_pend[u] = 1'b0;
                        tick[u] = 1'b1;
                        set_audio(u, 64'hDEAD_BEEF_0BAD_F00D);
                        model_push(u, 64'hDEAD_BEEF_0BAD_F00D);
                    end
                end else if (pend[u]) begin
                    pend[u] = 1'b0;
                    if (fidx[u] < nfeed[u]) begin
                        tick[u] = 1'b1;
                        set_audio(u, flist[u][fidx[u]]);
                        model_push(u, flist[u][fidx[u]]);
                        fidx[u]++;
                        if (fidx[u] == extra_at[u]) extra_pend[u] = 1'b1;
                    end
                end
                if (req_w[u]) begin
                    if (playing[u]) begin
                        logic [63:0] fr;
                        bit ok;
                        loads[u]++;
                        ok = 1'b0;
                        fr = '0;
                        if (u == 0 && mf0.size() > 0) begin fr = mf0.pop_front(); ok = 1'b1; end
                        if (u == 1 && mf1.size() > 0) begin fr = mf1.pop_front(); ok = 1'b1; end
                        if (!ok) und_exp[u] = 1'b1;
                        push_frame(u, fr);
                    end
                    pend[u] = 1'b1;
                end
            end
        end
    end

    // Monitor: checks sck timing and pops one expected bit per sck rising edge
    always @(negedge clk) begin
        cyc++;
        for (int u = 0; u < 2; u++) begin
            if (mon_off) begin
                prev_sck[u] = 1'b0;
                have_rise[u] = 1'b0;
            end else begin
                if (sck_w[u] && !prev_sck[u]) begin
                    if (have_rise[u] && rise_sess[u] == sess[u])
                        chk($sformatf("sck_period_u%0d", u), 64'(cyc - last_rise[u]), 64'(exp_div[u]));
                    have_rise[u] = 1'b1;
                    rise_sess[u] = sess[u];
                    last_rise[u] = cyc;
                    playing[u] = 1'b1;
                    if (qsz(u) == 0) begin
                        tmo($sformatf("unexpected_bit_u%0d", u));
                    end else begin
                        logic [1:0] it;
                        it = (u == 0) ? eq0.pop_front() : eq1.pop_front();
                        chk($sformatf("ws_sdo_u%0d_left%0d", u, qsz(u)), {62'b0, ws_w[u], sdo_w[u]}, {62'b0, it});
                    end
                end
                if (!sck_w[u] && prev_sck[u] && have_rise[u])
                    chk($sformatf("sck_high_u%0d", u), 64'(cyc - last_rise[u]), 64'(exp_div[u] / 2));
                prev_sck[u] = sck_w[u];
            end
        end
    end

    task automatic start_play(input int u);
        sess[u]++;
        loads[u] = 0;
        playing[u] = 1'b0;
        fidx[u] = 0;
        und_exp[u] = 1'b0;
        push_item(u, 2'b00);
        play[u] = 1'b1;
    endtask

    task automatic wait_loads(input int u, input int nl);
        int t;
        t = 0;
        while (loads[u] < nl && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TMO) tmo("load_wait");
    endtask

    task automatic check_idle(input int u, input string tag);
        chk({tag, "_sck"}, 64'(sck_w[u]), 64'd0);
        chk({tag, "_ws"},  64'(ws_w[u]),  64'd0);
        chk({tag, "_sdo"}, 64'(sdo_w[u]), 64'd0);
        chk({tag, "_req"}, 64'(req_w[u]), 64'd0);
        chk({tag, "_und"}, 64'(und_w[u]), 64'd0);
    endtask

    task automatic pulse_cfg0(input logic [31:0] v);
        @(negedge clk);
        cfg[0] = 1'b1;
        cfg_reg0 = v;
        @(negedge clk);
        cfg[0] = 1'b0;
    endtask

    // Play nl loaded frames, drop play_in mid-frame, let the frame finish, check STOP outputs
    task automatic session(input int u, input int nl, input bit cfg_mid);
        int t;
        start_play(u);
        wait_loads(u, nl);
        if (cfg_mid) begin
            @(negedge clk);
            cfg[0] = 1'b1;
            cfg_reg0 = 32'h2;
            @(negedge clk);
            cfg[0] = 1'b0;
        end
        repeat (20) @(negedge clk);
        chk($sformatf("underrun_u%0d", u), 64'(und_w[u]), 64'(und_exp[u]));
        play[u] = 1'b0;
        t = 0;
        while (qsz(u) != 0 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TMO) tmo("drain_wait");
        repeat (3 * exp_div[u] + 4) @(negedge clk);
        check_idle(u, $sformatf("stop_u%0d", u));
        chk($sformatf("leftover_u%0d", u), 64'(qsz(u)), 64'd0);
        if (u == 0) mf0.delete();
        else        mf1.delete();
    endtask

    initial begin
        int t;
        for (int u = 0; u < 2; u++) begin
            exp_div[u] = 8;
            exp_mode[u] = 1'b0;
            nfeed[u] = 0;
            extra_at[u] = 0;
            sess[u] = 0;
        end
        repeat (3) @(negedge clk);
        check_idle(0, "rst_u0");
        check_idle(1, "rst_u1");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Default I2S stereo, plus one extra tick while full that must be dropped
        flist[0][0] = {16'h0, 24'hABCDEF, 24'h123456};
        flist[0][1] = {16'h0, 24'h123456, 24'hABCDEF};
        flist[0][2] = {16'h0, 24'hABCDEF, 24'h123456};
        flist[0][3] = {16'h0, 24'h800001, 24'h7FFFFE};
        flist[0][4] = {16'h0, 24'hF0F0F0, 24'h0F0F0F};
        flist[0][5] = {16'h0, 24'hC3C3C3, 24'h5A5A5A};
        flist[0][6] = {16'h0, 24'hABCDEF, 24'h123456};
        flist[0][7] = {16'h0, 24'h000001, 24'h800000};
        nfeed[0] = 8;
        extra_at[0] = 6;
        session(0, 6, 1'b0);

        // TDM: four 16-bit channels, ws low for the first 32 bits
        flist[1][0] = 64'h1111_2222_3333_4444;
        flist[1][1] = 64'hA5A5_0F0F_F00F_5AA5;
        flist[1][2] = 64'h8001_7FFE_FFFF_0000;
        flist[1][3] = 64'h0123_4567_89AB_CDEF;
        flist[1][4] = 64'hFEDC_BA98_7654_3210;
        nfeed[1] = 5;
        extra_at[1] = 0;
        session(1, 3, 1'b0);

        // Configuration: 96 kHz left-justified; rate 11 keeps the divider; cfg during play ignored
        pulse_cfg0(32'h5);
        pulse_cfg0(32'h7);
        exp_div[0] = 4;
        exp_mode[0] = 1'b1;
        extra_at[0] = 0;
        session(0, 3, 1'b1);

        // Underrun: only the four fill frames are supplied
        nfeed[0] = 4;
        session(0, 6, 1'b0);

        // Asynchronous reset mid-frame while sck, ws and sdo are all high
        for (int i = 0; i < 8; i++) flist[0][i] = {16'h0, 48'hFFFF_FFFF_FFFF};
        nfeed[0] = 8;
        start_play(0);
        wait_loads(0, 2);
        t = 0;
        while (!(sck_w[0] && ws_w[0] && sdo_w[0]) && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TMO) tmo("high_wait");
        mon_off = 1'b1;
        play[0] = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_idle(0, "async_rst_u0");
        #1 rst = 1'b0;
        @(negedge clk);
        eq0.delete();
        mf0.delete();
        @(negedge clk);
        mon_off = 1'b0;

        // After reset the divider and mode are back to 48 kHz I2S
        exp_div[0] = 8;
        exp_mode[0] = 1'b0;
        flist[0][0] = {16'h0, 24'hABCDEF, 24'h123456};
        flist[0][1] = {16'h0, 24'h123456, 24'hABCDEF};
        session(0, 2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
